// File: rtl/vga_timing.sv
// Free-running raster timing generator (default geometry: 1024x768 @ 60 Hz, 65 MHz pixel clock).
// Counters, sync/blank flags and line/frame strobes are all registered together, so they never skew.
module vga_timing #(
  parameter int unsigned HOR_TOTAL_TIME  = 1344,
  parameter int unsigned HOR_BLANK_START = 1024,
  parameter int unsigned HOR_SYNC_START  = 1048,
  parameter int unsigned HOR_SYNC_STOP   = 1184,
  parameter int unsigned VER_TOTAL_TIME  = 806,
  parameter int unsigned VER_BLANK_START = 768,
  parameter int unsigned VER_SYNC_START  = 771,
  parameter int unsigned VER_SYNC_STOP   = 777
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        line_start,
  output logic        frame_start
);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == 11'(HOR_TOTAL_TIME - 1)) begin
      hcount_d = '0;
      if (vcount_q == 11'(VER_TOTAL_TIME - 1)) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next-state counters so they land in the same cycle as the count they describe.
  always_comb begin
    hblnk_d       = (hcount_d >= 11'(HOR_BLANK_START));
    hsync_d       = (hcount_d >= 11'(HOR_SYNC_START)) && (hcount_d < 11'(HOR_SYNC_STOP));
    vblnk_d       = (vcount_d >= 11'(VER_BLANK_START));
    vsync_d       = (vcount_d >= 11'(VER_SYNC_START)) && (vcount_d < 11'(VER_SYNC_STOP));
    line_start_d  = (hcount_d == '0);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
